wb_multi_issue: RTL and testbench

Parametrised writeback stage for the multi-issue pipeline, successor to the single-lane WB stage. Registers a bundle of LANES retiring instructions from MEM and drives the register-file and HI/LO write bus. Masks same-register write conflicts inside a bundle. Serialises all retirements, in program order, through a multi-push/single-pop trace FIFO onto the single-lane debug port, and raises a stall request before that FIFO can overflow.

---
 rtl/wb_multi_issue_pkg.sv | 25 ++
 rtl/wb_trace_fifo.sv | 75 +++++++
 rtl/wb_multi_issue.sv | 126 ++++++++++++
 tb/tb_wb_multi_issue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_multi_issue_pkg.sv
// Shared field layout and bus-width helpers for the multi-issue writeback stage.
package wb_multi_issue_pkg;

    localparam int LANE_W    = 71;
    localparam int HILO_W    = 66;
    localparam int RF_LANE_W = 38;

    localparam int WDATA_LSB = 0;
    localparam int WADDR_LSB = 32;
    localparam int WE_BIT    = 37;
    localparam int PC_LSB    = 38;
    localparam int VALID_BIT = 70;

    // A trace entry is the lane without its valid bit: {pc, we, waddr, wdata}.
    localparam int TRACE_W   = 70;

    function automatic int mem_bus_w(input int lanes);
        return lanes * LANE_W + HILO_W;
    endfunction

    function automatic int rf_bus_w(input int lanes);
        return lanes * RF_LANE_W + HILO_W;
    endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Multi-push / single-pop trace FIFO; valid push lanes are packed in lane order.
module wb_trace_fifo #(
    parameter int WIDTH = 70,
    parameter int DEPTH = 8,
    parameter int LANES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES-1:0]           push_valid_i,
    input  logic [LANES*WIDTH-1:0]     push_data_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       pop_valid_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             pop_valid_q, pop_valid_d;

    logic [AW-1:0]    slot [LANES];
    logic [AW:0]      push_cnt;
    logic             do_pop;

    // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            slot[i]  = wr_ptr_q + push_cnt[AW-1:0];
            push_cnt = push_cnt + (AW+1)'(push_valid_i[i]);
        end
    end

    always_comb begin
        do_pop      = pop_i && (count_q != '0);
        wr_ptr_d    = wr_ptr_q + push_cnt[AW-1:0];
        rd_ptr_d    = rd_ptr_q + AW'(do_pop);
        count_d     = count_q + push_cnt - (AW+1)'(do_pop);
        dout_d      = do_pop ? mem[rd_ptr_q] : '0;
        pop_valid_d = do_pop;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (push_valid_i[i]) begin
                mem[slot[i]] <= push_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            pop_valid_q <= pop_valid_d;
        end
    end

    assign count_o     = count_q;
    assign dout_o      = dout_q;
    assign pop_valid_o = pop_valid_q;

endmodule

// File: rtl/wb_multi_issue.sv
// Multi-issue writeback stage: bundle register, RF write bus with same-register
// conflict masking, and an in-order trace serialiser onto the debug port.
module wb_multi_issue
    import wb_multi_issue_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int TRACE_DEPTH = 8,
    parameter int STALL_W     = 6,
    parameter int STAGE_IDX   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [STALL_W-1:0]           stall,
    input  logic                         flush,
    input  logic [mem_bus_w(LANES)-1:0]  mem_to_wb_bus,
    output logic [rf_bus_w(LANES)-1:0]   wb_to_rf_bus,
    output logic                         stall_req,
    output logic [31:0]                  debug_wb_pc,
    output logic [3:0]                   debug_wb_rf_wen,
    output logic [4:0]                   debug_wb_rf_wnum,
    output logic [31:0]                  debug_wb_rf_wdata
);
    localparam int MEM_W = mem_bus_w(LANES);
    localparam int RF_W  = rf_bus_w(LANES);
    localparam int CNT_W = $clog2(TRACE_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    logic [MEM_W-1:0] bundle_q, bundle_d;
    logic             fresh_q, fresh_d;

    always_comb begin
        bundle_d = bundle_q;
        fresh_d  = 1'b0;
        if (flush) begin
            bundle_d = '0;
        end else if (stall[STAGE_IDX] && !stall[STAGE_IDX+1]) begin
            bundle_d = '0;
        end else if (!stall[STAGE_IDX]) begin
            bundle_d = mem_to_wb_bus;
            fresh_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_q <= '0;
            fresh_q  <= 1'b0;
        end else begin
            bundle_q <= bundle_d;
            fresh_q  <= fresh_d;
        end
    end

    logic [LANES-1:0]         lane_valid, lane_we, rf_we_out, push_valid;
    logic [4:0]               lane_waddr [LANES];
    logic [31:0]              lane_wdata [LANES];
    logic [LANES*TRACE_W-1:0] push_data;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam int B = gi * LANE_W;
        assign lane_valid[gi] = bundle_q[B + VALID_BIT];
        assign lane_we[gi]    = bundle_q[B + WE_BIT];
        assign lane_waddr[gi] = bundle_q[B + WADDR_LSB +: 5];
        assign lane_wdata[gi] = bundle_q[B + WDATA_LSB +: 32];
        assign push_valid[gi] = fresh_q & lane_valid[gi];
        assign push_data[gi*TRACE_W +: TRACE_W] = bundle_q[B +: TRACE_W];
        assign wb_to_rf_bus[gi*RF_LANE_W +: RF_LANE_W] =
            {rf_we_out[gi], lane_waddr[gi], lane_wdata[gi]};
    end

    assign wb_to_rf_bus[RF_W-1 -: HILO_W] = bundle_q[MEM_W-1 -: HILO_W];

    // A younger lane writing the same register wins; the older write is dropped.
    always_comb begin
        rf_we_out = '0;
        for (int i = 0; i < LANES; i++) begin
            rf_we_out[i] = lane_valid[i] & lane_we[i] & (lane_waddr[i] != 5'd0);
            for (int j = i + 1; j < LANES; j++) begin
                if (lane_valid[j] && lane_we[j] && (lane_waddr[j] == lane_waddr[i])) begin
                    rf_we_out[i] = 1'b0;
                end
            end
        end
    end

    logic [CNT_W-1:0]   fifo_count;
    logic [TRACE_W-1:0] trace_dout;
    logic               trace_pop_valid;

    wb_trace_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (TRACE_DEPTH),
        .LANES (LANES)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_valid_i (push_valid),
        .push_data_i  (push_data),
        .pop_i        (1'b1),
        .count_o      (fifo_count),
        .dout_o       (trace_dout),
        .pop_valid_o  (trace_pop_valid)
    );

    // Back-pressure counts the registered bundle's pending pushes but not this cycle's pop.
    logic [SUM_W-1:0] pending;
    always_comb begin
        pending = '0;
        if (fresh_q) begin
            for (int i = 0; i < LANES; i++) begin
                pending = pending + SUM_W'(lane_valid[i]);
            end
        end
    end

    assign stall_req = (SUM_W'(fifo_count) + pending) > SUM_W'(TRACE_DEPTH - LANES);

    assign debug_wb_pc       = trace_dout[PC_LSB +: 32];
    assign debug_wb_rf_wen   = {4{trace_pop_valid & trace_dout[WE_BIT]}};
    assign debug_wb_rf_wnum  = trace_dout[WADDR_LSB +: 5];
    assign debug_wb_rf_wdata = trace_dout[WDATA_LSB +: 32];

    logic stall_unused;
    assign stall_unused = ^stall;

endmodule

// File: tb/tb_wb_multi_issue.sv
// Bench for wb_multi_issue: hand table, reset-mid-burst sequence and a randomized
// run against a queue-based reference model (LANES=2, TRACE_DEPTH=4).
module tb_wb_multi_issue;
    localparam int LANES = 2;
    localparam int DEPTH = 4;
    localparam int MEM_W = 208;
    localparam int RF_W  = 142;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [5:0]       stall = '0;
    logic             flush = 1'b0;
    logic [MEM_W-1:0] mem_bus = '0;
    logic [RF_W-1:0]  rf_bus;
    logic             stall_req;
    logic [31:0]      dbg_pc, dbg_wdata;
    logic [3:0]       dbg_wen;
    logic [4:0]       dbg_wnum;

    always #5 clk = ~clk;

    wb_multi_issue #(
        .LANES       (LANES),
        .TRACE_DEPTH (DEPTH),
        .STALL_W     (6),
        .STAGE_IDX   (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .flush             (flush),
        .mem_to_wb_bus     (mem_bus),
        .wb_to_rf_bus      (rf_bus),
        .stall_req         (stall_req),
        .debug_wb_pc       (dbg_pc),
        .debug_wb_rf_wen   (dbg_wen),
        .debug_wb_rf_wnum  (dbg_wnum),
        .debug_wb_rf_wdata (dbg_wdata)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: registered bundle, fresh flag, queue of retired-but-not-shown entries.
    logic [MEM_W-1:0] m_reg = '0;
    bit               m_fresh = 1'b0;
    logic [69:0]      m_q[$];
    logic [69:0]      m_dbg = '0;

    function automatic logic [70:0] mk_lane(bit v, logic [31:0] pc, bit we,
                                            logic [4:0] wa, logic [31:0] wd);
        return {v, pc, we, wa, wd};
    endfunction

    task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_reg = '0;
        m_fresh = 1'b0;
        m_q.delete();
        m_dbg = '0;
    endtask

    task automatic model_edge();
        logic [70:0] l;
        m_dbg = (m_q.size() != 0) ? m_q.pop_front() : '0;
        if (m_fresh) begin
            for (int i = 0; i < LANES; i++) begin
                l = m_reg[i*71 +: 71];
                if (l[70]) m_q.push_back(l[69:0]);
            end
        end
        if (flush || (stall[4] && !stall[5])) begin
            m_reg = '0;
            m_fresh = 1'b0;
        end else if (!stall[4]) begin
            m_reg = mem_bus;
            m_fresh = 1'b1;
        end else begin
            m_fresh = 1'b0;
        end
    endtask

    task automatic model_check();
        logic [RF_W-1:0] e;
        logic [70:0]     l;
        bit [31:0]       seen;
        int              pend;
        bit              wr;
        e = '0;
        seen = '0;
        pend = 0;
        e[RF_W-1 -: 66] = m_reg[MEM_W-1 -: 66];
        for (int i = LANES - 1; i >= 0; i--) begin
            l = m_reg[i*71 +: 71];
            wr = l[70] && l[37] && (l[36:32] != 5'd0) && !seen[l[36:32]];
            e[i*38 +: 38] = {wr, l[36:32], l[31:0]};
            if (l[70] && l[37]) seen[l[36:32]] = 1'b1;
            if (m_fresh && l[70]) pend++;
        end
        chk("rf_bus", 160'(rf_bus), 160'(e));
        chk("stall_req", 160'(stall_req), 160'((DEPTH - m_q.size() - pend) < LANES));
        chk("debug", {dbg_pc, dbg_wen, dbg_wnum, dbg_wdata},
            {m_dbg[69:38], {4{m_dbg[37]}}, m_dbg[36:32], m_dbg[31:0]});
        chk("fifo_count", 160'(dut.fifo_count), 160'(m_q.size()));
        chk("count_bound", 160'(dut.fifo_count <= DEPTH), 160'(1));
    endtask

    task automatic step(input logic [5:0] st, input logic fl, input logic [MEM_W-1:0] bus);
        stall = st;
        flush = fl;
        mem_bus = bus;
        model_edge();
        @(posedge clk);
        #1;
        model_check();
    endtask

    typedef struct {
        logic [5:0]       st;
        logic [MEM_W-1:0] bus;
        logic [1:0]       e_we;
        logic             e_sr;
        logic [31:0]      e_pc;
        logic [3:0]       e_wen;
        logic [31:0]      e_wd;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [MEM_W-1:0] b_a, b_b, b_c, b_e, rb;
        logic [5:0]       st;

        b_a = {1'b1, 32'h1234_5678, 1'b0, 32'h9ABC_DEF0,
               mk_lane(1, 32'hBFC0_0004, 1, 5'd4, 32'h22),
               mk_lane(1, 32'hBFC0_0000, 1, 5'd3, 32'h11)};
        b_b = {66'd0, mk_lane(1, 32'hBFC0_000C, 1, 5'd5, 32'hBB),
                      mk_lane(1, 32'hBFC0_0008, 1, 5'd5, 32'hAA)};
        b_c = {66'd0, mk_lane(0, 32'hBFC0_0014, 1, 5'd6, 32'h44),
                      mk_lane(1, 32'hBFC0_0010, 1, 5'd0, 32'h33)};
        b_e = {66'd0, mk_lane(0, 32'hBFC0_0104, 0, 5'd1, 32'h0),
                      mk_lane(1, 32'hBFC0_0100, 1, 5'd7, 32'h77)};

        tbl[0] = '{6'h00, b_a, 2'b11, 1'b0, 32'h0,         4'h0, 32'h0};
        tbl[1] = '{6'h00, b_b, 2'b10, 1'b1, 32'h0,         4'h0, 32'h0};
        tbl[2] = '{6'h10, b_c, 2'b00, 1'b1, 32'hBFC0_0000, 4'hF, 32'h11};
        tbl[3] = '{6'h10, b_c, 2'b00, 1'b0, 32'hBFC0_0004, 4'hF, 32'h22};
        tbl[4] = '{6'h00, b_c, 2'b00, 1'b0, 32'hBFC0_0008, 4'hF, 32'hAA};
        tbl[5] = '{6'h30, b_a, 2'b00, 1'b0, 32'hBFC0_000C, 4'hF, 32'hBB};
        tbl[6] = '{6'h30, b_a, 2'b00, 1'b0, 32'hBFC0_0010, 4'hF, 32'h33};
        tbl[7] = '{6'h30, b_a, 2'b00, 1'b0, 32'h0,         4'h0, 32'h0};
        tbl[8] = '{6'h30, b_a, 2'b00, 1'b0, 32'h0,         4'h0, 32'h0};
        tbl[9] = '{6'h10, b_a, 2'b00, 1'b0, 32'h0,         4'h0, 32'h0};

        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_rf", 160'(rf_bus), 160'(0));
        chk("reset_sr", 160'(stall_req), 160'(0));
        chk("reset_dbg", {dbg_pc, dbg_wen, dbg_wnum, dbg_wdata}, 160'(0));
        #2 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].st, 1'b0, tbl[i].bus);
            chk($sformatf("tbl%0d_we", i), 160'({rf_bus[75], rf_bus[37]}), 160'(tbl[i].e_we));
            chk($sformatf("tbl%0d_sr", i), 160'(stall_req), 160'(tbl[i].e_sr));
            chk($sformatf("tbl%0d_dbg", i), {dbg_pc, dbg_wen, dbg_wdata},
                {tbl[i].e_pc, tbl[i].e_wen, tbl[i].e_wd});
        end

        // Fill the FIFO to three entries, then reset in the middle of a cycle.
        step(6'h00, 1'b0, b_a);
        step(6'h00, 1'b0, b_b);
        step(6'h10, 1'b0, b_a);
        chk("pre_reset_count", 160'(dut.fifo_count), 160'(3));
        #2 rst = 1'b1;
        #1;
        chk("midrst_rf", 160'(rf_bus), 160'(0));
        chk("midrst_sr", 160'(stall_req), 160'(0));
        chk("midrst_dbg", {dbg_pc, dbg_wen, dbg_wnum, dbg_wdata}, 160'(0));
        chk("midrst_count", 160'(dut.fifo_count), 160'(0));
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        step(6'h00, 1'b0, b_e);
        step(6'h00, 1'b0, '0);
        step(6'h00, 1'b0, '0);
        chk("post_reset_first", {dbg_pc, dbg_wen, dbg_wdata},
            {32'hBFC0_0100, 4'hF, 32'h77});

        // Randomized traffic with flushes and back-pressure honoured by the upstream stall.
        for (int n = 0; n < 600; n++) begin
            rb = '0;
            rb[MEM_W-1 -: 66] = {$urandom, $urandom, $urandom};
            for (int i = 0; i < LANES; i++) begin
                rb[i*71 +: 71] = mk_lane($urandom_range(0, 3) != 0,
                                         32'hBFC0_0000 + 32'(n * 8 + i * 4),
                                         bit'($urandom_range(0, 1)),
                                         5'($urandom_range(0, 3)), $urandom);
            end
            st = 6'($urandom);
            st[4] = ($urandom_range(0, 3) == 0) || stall_req;
            step(st, $urandom_range(0, 19) == 0, rb);
        end
        for (int n = 0; n < 8; n++) begin
            step(6'h00, 1'b0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
